ub_input_feeder: RTL and testbench

- Read-side client of the unified buffer. It issues load_input/addr requests, captures the 4-word 2x2 tile that the buffer returns one cycle later, and drives the tile into the left edge of the 2x2 systolic array with diagonal skew.
- Streams N consecutive tiles back-to-back, one tile every 3 cycles, by prefetching the next tile during the current skew.
- Sits between the controller (start/base/count) and the systolic array row inputs.

---
 rtl/tpu_pkg.sv | 20 ++
 rtl/ub_input_feeder_if.sv | 45 ++++
 rtl/ub_input_feeder_skew_mux.sv | 41 ++++
 rtl/ub_input_feeder.sv | 140 ++++++++++++++
 tb/tb_ub_input_feeder.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU datapath.
// Holds the input-feeder state encoding and tile geometry.
package tpu_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 13;
  localparam int CNT_WIDTH  = 8;
  localparam int TILE_WORDS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_LATCH,
    ST_SKEW0,
    ST_SKEW1,
    ST_SKEW2,
    ST_DONE
  } feeder_state_t;

endpackage

// File: rtl/ub_input_feeder_if.sv
// Bundle between controller, unified buffer and array.
// master = the feeder, slave = its environment.
interface ub_input_feeder_if #(
  parameter int DATA_WIDTH = tpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = tpu_pkg::ADDR_WIDTH,
  parameter int CNT_WIDTH  = tpu_pkg::CNT_WIDTH
);

  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [CNT_WIDTH-1:0]  num_tiles;
  logic                  ub_load_input;
  logic [ADDR_WIDTH-1:0] ub_addr;
  logic [DATA_WIDTH-1:0] ub_in_00;
  logic [DATA_WIDTH-1:0] ub_in_01;
  logic [DATA_WIDTH-1:0] ub_in_10;
  logic [DATA_WIDTH-1:0] ub_in_11;
  logic [DATA_WIDTH-1:0] a_row0;
  logic [DATA_WIDTH-1:0] a_row1;
  logic                  a_valid0;
  logic                  a_valid1;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, base_addr, num_tiles,
    input  ub_in_00, ub_in_01,
    input  ub_in_10, ub_in_11,
    output ub_load_input, ub_addr,
    output a_row0, a_row1,
    output a_valid0, a_valid1,
    output busy, done
  );

  modport slave (
    output start, base_addr, num_tiles,
    output ub_in_00, ub_in_01,
    output ub_in_10, ub_in_11,
    input  ub_load_input, ub_addr,
    input  a_row0, a_row1,
    input  a_valid0, a_valid1,
    input  busy, done
  );

endinterface

// File: rtl/ub_input_feeder_skew_mux.sv
// Selects row data/valids for one skew phase of a 2x2 tile.
// Tile word order: [0]=m00 [1]=m01 [2]=m10 [3]=m11.
module skew_mux
  import tpu_pkg::*;
#(
  parameter int DATA_WIDTH = tpu_pkg::DATA_WIDTH
) (
  input  feeder_state_t                state_i,
  input  logic [3:0][DATA_WIDTH-1:0]   tile_i,
  output logic [DATA_WIDTH-1:0]        row0_o,
  output logic [DATA_WIDTH-1:0]        row1_o,
  output logic                         valid0_o,
  output logic                         valid1_o
);

  // Diagonal skew: row 1 lags row 0 by one cycle.
  always_comb begin
    row0_o   = '0;
    row1_o   = '0;
    valid0_o = 1'b0;
    valid1_o = 1'b0;
    unique case (1'b1)
      (state_i == ST_SKEW0): begin
        row0_o   = tile_i[0];
        valid0_o = 1'b1;
      end
      (state_i == ST_SKEW1): begin
        row0_o   = tile_i[1];
        valid0_o = 1'b1;
        row1_o   = tile_i[2];
        valid1_o = 1'b1;
      end
      (state_i == ST_SKEW2): begin
        row1_o   = tile_i[3];
        valid1_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ub_input_feeder.sv
// Unified-buffer read client feeding the 2x2 array.
// Prefetches the next tile in SKEW1 to stream back-to-back.
module ub_input_feeder
  import tpu_pkg::*;
#(
  parameter int DATA_WIDTH = tpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = tpu_pkg::ADDR_WIDTH,
  parameter int CNT_WIDTH  = tpu_pkg::CNT_WIDTH
) (
  input logic               clk,
  input logic               reset,
  ub_input_feeder_if.master bus
);

  typedef logic [3:0][DATA_WIDTH-1:0] tile_t;

  feeder_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  tile_t                 tile_q, tile_d;

  logic                  ld_q, ld_d;
  logic [ADDR_WIDTH-1:0] uaddr_q, uaddr_d;
  logic [DATA_WIDTH-1:0] row0_q, row0_d;
  logic [DATA_WIDTH-1:0] row1_q, row1_d;
  logic                  v0_q, v0_d;
  logic                  v1_q, v1_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  tile_t                 ub_tile;
  logic                  more;

  assign ub_tile = {bus.ub_in_11, bus.ub_in_10,
                    bus.ub_in_01, bus.ub_in_00};
  assign more    = rem_q > CNT_WIDTH'(1);

  // Next state, address/count bookkeeping and tile capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    tile_d  = tile_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.num_tiles != '0) begin
            addr_d  = bus.base_addr;
            rem_d   = bus.num_tiles;
            state_d = ST_REQ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_REQ:   state_d = ST_LATCH;
      ST_LATCH: begin
        tile_d  = ub_tile;
        addr_d  = addr_q + ADDR_WIDTH'(TILE_WORDS);
        state_d = ST_SKEW0;
      end
      ST_SKEW0: state_d = ST_SKEW1;
      ST_SKEW1: state_d = ST_SKEW2;
      ST_SKEW2: begin
        rem_d = rem_q - CNT_WIDTH'(1);
        if (more) begin
          tile_d  = ub_tile;
          addr_d  = addr_q + ADDR_WIDTH'(TILE_WORDS);
          state_d = ST_SKEW0;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  skew_mux #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skew_mux (
    .state_i  (state_d),
    .tile_i   (tile_d),
    .row0_o   (row0_d),
    .row1_o   (row1_d),
    .valid0_o (v0_d),
    .valid1_o (v1_d)
  );

  // Outputs are decoded from next state so they register cleanly.
  always_comb begin
    ld_d    = (state_d == ST_REQ) ||
              ((state_d == ST_SKEW1) &&
               (rem_d > CNT_WIDTH'(1)));
    uaddr_d = ld_d ? addr_d : '0;
    busy_d  = state_d != ST_IDLE;
    done_d  = state_d == ST_DONE;
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      tile_q  <= '0;
      ld_q    <= 1'b0;
      uaddr_q <= '0;
      row0_q  <= '0;
      row1_q  <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      tile_q  <= tile_d;
      ld_q    <= ld_d;
      uaddr_q <= uaddr_d;
      row0_q  <= row0_d;
      row1_q  <= row1_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.ub_load_input = ld_q;
  assign bus.ub_addr       = uaddr_q;
  assign bus.a_row0        = row0_q;
  assign bus.a_row1        = row1_q;
  assign bus.a_valid0      = v0_q;
  assign bus.a_valid1      = v1_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_ub_input_feeder.sv
// Testbench for ub_input_feeder.
// Per-cycle expected outputs are queued at start and popped each cycle.
module tb_ub_input_feeder;

  logic clk;
  logic reset;

  ub_input_feeder_if bus ();

  ub_input_feeder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ld;
    logic [12:0] addr;
    logic [7:0]  r0;
    logic        v0;
    logic [7:0]  r1;
    logic        v1;
    logic        busy;
    logic        done;
  } obs_t;

  logic [7:0] mem [8192];
  obs_t       exp_q [$];
  int         n_checks;
  int         n_fail;

  // Unified buffer: data valid the cycle after a request.
  always @(posedge clk) begin
    if (bus.ub_load_input) begin
      bus.ub_in_00 <= mem[bus.ub_addr];
      bus.ub_in_01 <= mem[bus.ub_addr + 13'd1];
      bus.ub_in_10 <= mem[bus.ub_addr + 13'd2];
      bus.ub_in_11 <= mem[bus.ub_addr + 13'd3];
    end else begin
      bus.ub_in_00 <= 8'($urandom);
      bus.ub_in_01 <= 8'($urandom);
      bus.ub_in_10 <= 8'($urandom);
      bus.ub_in_11 <= 8'($urandom);
    end
  end

  function automatic obs_t sample();
    obs_t o;
    o.ld   = bus.ub_load_input;
    o.addr = bus.ub_addr;
    o.r0   = bus.a_row0;
    o.v0   = bus.a_valid0;
    o.r1   = bus.a_row1;
    o.v1   = bus.a_valid1;
    o.busy = bus.busy;
    o.done = bus.done;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf(
      "ld=%b addr=%0d r0=%0d v0=%b r1=%0d v1=%b busy=%b done=%b",
      o.ld, o.addr, o.r0, o.v0, o.r1, o.v1, o.busy, o.done);
  endfunction

  function automatic void push_trace(logic [12:0] base,
                                     logic [7:0] n);
    obs_t        o;
    logic [12:0] a;
    if (n == 0) begin
      o = '0; o.busy = 1; o.done = 1;
      exp_q.push_back(o);
    end else begin
      o = '0; o.busy = 1; o.ld = 1; o.addr = base;
      exp_q.push_back(o);
      o = '0; o.busy = 1;
      exp_q.push_back(o);
      for (int t = 0; t < int'(n); t++) begin
        a = base + 13'(4 * t);
        o = '0; o.busy = 1; o.r0 = mem[a]; o.v0 = 1;
        exp_q.push_back(o);
        o = '0; o.busy = 1;
        o.r0 = mem[a + 13'd1]; o.v0 = 1;
        o.r1 = mem[a + 13'd2]; o.v1 = 1;
        if (t < int'(n) - 1) begin
          o.ld = 1; o.addr = a + 13'd4;
        end
        exp_q.push_back(o);
        o = '0; o.busy = 1; o.r1 = mem[a + 13'd3]; o.v1 = 1;
        exp_q.push_back(o);
      end
      o = '0; o.busy = 1; o.done = 1;
      exp_q.push_back(o);
    end
    o = '0;
    exp_q.push_back(o);
    exp_q.push_back(o);
  endfunction

  task automatic run(input string nm, input logic [12:0] base,
                     input logic [7:0] n, input int extra);
    obs_t got, e;
    int   cyc;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.num_tiles = n;
    push_trace(base, n);
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      got = sample();
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %s, expected %s",
                 nm, cyc, fmt(got), fmt(e));
      end
      if (cyc == extra) begin
        bus.start     = 1'b1;
        bus.base_addr = 13'($urandom);
        bus.num_tiles = 8'd5;
      end else begin
        bus.start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    obs_t got;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.start     = 1'($urandom);
      bus.base_addr = 13'($urandom);
      bus.num_tiles = 8'($urandom);
      @(negedge clk);
      got = sample();
      n_checks++;
      if (got !== '0) begin
        n_fail++;
        $display("FAIL reset_hold: got %s, expected all 0",
                 fmt(got));
      end
    end
    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    got = sample();
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got %s, expected all 0",
               fmt(got));
    end
  endtask

  task automatic test_single();
    mem[8]  = 8'd1;
    mem[9]  = 8'd2;
    mem[10] = 8'd3;
    mem[11] = 8'd4;
    run("single", 13'd8, 8'd1, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) mem[i] = 8'(i + 1);
    // extra start lands in the DONE cycle and must be ignored
    run("stream", 13'd0, 8'd3, 12);
  endtask

  task automatic test_zero();
    run("zero", 13'd100, 8'd0, -1);
  endtask

  task automatic test_wrap_busy();
    run("wrap", 13'd8188, 8'd2, 4);
    run("wrap8190", 13'd8190, 8'd2, -1);
  endtask

  task automatic test_reset_mid();
    obs_t got;
    bool_chk: begin
      @(negedge clk);
      bus.start     = 1'b1;
      bus.base_addr = 13'd40;
      bus.num_tiles = 8'd3;
      for (int c = 1; c <= 7; c++) begin
        @(negedge clk);
        bus.start = 1'b0;
      end
      got = sample();
      n_checks++;
      if (got.ld !== 1'b1 || got.addr !== 13'd48 ||
          got.r0 !== mem[45] || got.r1 !== mem[46]) begin
        n_fail++;
        $display("FAIL mid_skew1: got %s, expected ld=1 addr=48",
                 fmt(got));
      end
    end
    #1 reset = 1'b0;
    #1 got = sample();
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL mid_async: got %s, expected all 0",
               fmt(got));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = sample();
      n_checks++;
      if (got !== '0) begin
        n_fail++;
        $display("FAIL mid_hold: got %s, expected all 0",
                 fmt(got));
      end
    end
    reset = 1'b1;
    @(negedge clk);
    got = sample();
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL mid_release: got %s, expected all 0",
               fmt(got));
    end
    run("restart", 13'd40, 8'd3, -1);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.num_tiles = '0;
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    test_reset();
    test_single();
    test_back_to_back();
    test_zero();
    test_wrap_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
